// File: rtl/s420_cfg_feeder.sv
// Serial compare-word loader and run controller feeding the s420 counter core.
// A shadow register double-buffers the next word while the current run counts.
//
// state | meaning
// IDLE  | P0 low, C holds last committed word, waiting for a commit
// RUN   | P0 follows ~HALT; counts enabled cycles down to termination
module s420_cfg_feeder #(
    parameter int CW  = 17,
    parameter int RLW = 8
) (
    input  logic           CK,
    input  logic           RN,
    input  logic           SI,
    input  logic           SV,
    output logic           SR,
    input  logic           GO,
    input  logic [RLW-1:0] RUN_LEN,
    input  logic           HALT,
    input  logic           STOP,
    output logic [CW-1:0]  C,
    output logic           P0,
    output logic           BUSY,
    output logic           DONE
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int BW = $clog2(CW + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(CW - 1);

    state_t         state;
    logic [CW-1:0]  shadow;
    logic [BW-1:0]  bitcnt;
    logic           full;
    logic [RLW-1:0] cnt;
    logic           free;
    logic           commit;

    assign commit = GO & full & ~STOP;
    assign SR     = ~full;
    assign BUSY   = (state == RUN);

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state  <= IDLE;
            shadow <= '0;
            bitcnt <= '0;
            full   <= 1'b0;
            cnt    <= '0;
            free   <= 1'b0;
            C      <= '0;
            P0     <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            DONE <= 1'b0;

            // Shift only while the shadow has room; a full shadow freezes until committed.
            if (SV && !full) begin
                shadow <= {SI, shadow[CW-1:1]};
                if (bitcnt == LAST_BIT) begin
                    full   <= 1'b1;
                    bitcnt <= '0;
                end else begin
                    bitcnt <= bitcnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    P0 <= 1'b0;
                    if (commit) begin
                        C     <= shadow;
                        full  <= 1'b0;
                        cnt   <= RUN_LEN;
                        free  <= (RUN_LEN == '0);
                        state <= RUN;
                        P0    <= ~HALT;
                    end
                end
                RUN: begin
                    if (STOP) begin
                        state <= IDLE;
                        P0    <= 1'b0;
                    end else if (commit) begin
                        C     <= shadow;
                        full  <= 1'b0;
                        cnt   <= RUN_LEN;
                        free  <= (RUN_LEN == '0);
                        P0    <= ~HALT;
                    end else if (P0 && !free && cnt == RLW'(1)) begin
                        state <= IDLE;
                        P0    <= 1'b0;
                        DONE  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        // Only cycles where the core actually counted consume run length.
                        if (P0 && !free)
                            cnt <= cnt - 1'b1;
                        P0 <= ~HALT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s420_cfg_feeder.sv
// Scoreboard bench for s420_cfg_feeder: per-cycle stimulus/expectation schedule
// plus a queue of shifted words consumed at each expected commit.
module tb_s420_cfg_feeder;

    logic        CK = 1'b0;
    logic        RN;
    logic        SI, SV, GO, HALT, STOP;
    logic [7:0]  RUN_LEN;
    logic        SR, P0, BUSY, DONE;
    logic [16:0] C;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         go, halt, stop, sv, si;
        logic [7:0] rl;
        bit         commit;
        bit         p0, done, busy, sr;
    } cyc_t;

    cyc_t        sched[$];
    logic [16:0] wq[$];
    logic [16:0] exp_c;

    s420_cfg_feeder #(.CW(17), .RLW(8)) dut (
        .CK(CK), .RN(RN), .SI(SI), .SV(SV), .SR(SR), .GO(GO),
        .RUN_LEN(RUN_LEN), .HALT(HALT), .STOP(STOP),
        .C(C), .P0(P0), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CK = ~CK;

    function automatic void add(bit go, bit halt, bit stop, bit sv, bit si, logic [7:0] rl,
                                bit commit, bit p0, bit done, bit busy, bit sr);
        cyc_t e;
        e.go = go; e.halt = halt; e.stop = stop; e.sv = sv; e.si = si; e.rl = rl;
        e.commit = commit; e.p0 = p0; e.done = done; e.busy = busy; e.sr = sr;
        sched.push_back(e);
    endfunction

    // 17 one-per-cycle beats, LSB first; SR must drop only after the last beat.
    function automatic void add_shift(logic [16:0] w, bit p0, bit busy);
        for (int i = 0; i < 17; i++)
            add(0, 0, 0, 1, w[i], 8'd0, 0, p0, 0, busy, i != 16);
        wq.push_back(w);
    endfunction

    task automatic drive(input cyc_t e);
        GO = e.go; HALT = e.halt; STOP = e.stop; SV = e.sv; SI = e.si; RUN_LEN = e.rl;
        @(posedge CK);
        #1;
        if (e.commit && wq.size() != 0)
            exp_c = wq.pop_front();
    endtask

    task automatic test_reset;
        cyc_t e;
        int   n;
        RN = 1'b1; GO = 0; HALT = 0; STOP = 0; SV = 0; SI = 0; RUN_LEN = 0;
        #3 RN = 1'b0;
        #1;
        checks++;
        if ({C, P0, DONE, BUSY, SR} !== {17'h0, 4'b0001}) begin
            errors++;
            $display("FAIL reset_initial: {C,P0,DONE,BUSY,SR} got %h want %h",
                     {C, P0, DONE, BUSY, SR}, {17'h0, 4'b0001});
        end
        @(negedge CK) RN = 1'b1;
        exp_c = '0;

        add_shift(17'h15555, 0, 0);
        add(1, 0, 0, 0, 0, 8'd50, 1, 1, 0, 1, 1);
        for (int i = 0; i < 9; i++)
            add(0, 0, 0, 1, i[0], 8'd0, 0, 1, 0, 1, 1);
        n = 0;
        while (sched.size() != 0) begin
            e = sched.pop_front();
            drive(e);
            n++;
            checks++;
            if ({C, P0, DONE, BUSY, SR} !== {exp_c, e.p0, e.done, e.busy, e.sr}) begin
                errors++;
                $display("FAIL reset_prerun cyc %0d: {C,P0,DONE,BUSY,SR} got %h want %h",
                         n, {C, P0, DONE, BUSY, SR}, {exp_c, e.p0, e.done, e.busy, e.sr});
            end
        end

        // Asynchronous reset mid-run with 9 bits of the next word already shifted.
        #3 RN = 1'b0;
        #1;
        checks++;
        if ({C, P0, DONE, BUSY, SR} !== {17'h0, 4'b0001}) begin
            errors++;
            $display("FAIL reset_midrun: {C,P0,DONE,BUSY,SR} got %h want %h",
                     {C, P0, DONE, BUSY, SR}, {17'h0, 4'b0001});
        end
        @(negedge CK) RN = 1'b1;
        exp_c = '0;

        add_shift(17'h0ABCD, 0, 0);
        add(1, 0, 0, 0, 0, 8'd1, 1, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 8'd0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0, 1);
        n = 0;
        while (sched.size() != 0) begin
            e = sched.pop_front();
            drive(e);
            n++;
            checks++;
            if ({C, P0, DONE, BUSY, SR} !== {exp_c, e.p0, e.done, e.busy, e.sr}) begin
                errors++;
                $display("FAIL reset_reload cyc %0d: {C,P0,DONE,BUSY,SR} got %h want %h",
                         n, {C, P0, DONE, BUSY, SR}, {exp_c, e.p0, e.done, e.busy, e.sr});
            end
        end
    endtask

    task automatic test_basic_run;
        cyc_t e;
        int   n;
        add_shift(17'h1A5A5, 0, 0);
        add(1, 0, 0, 0, 0, 8'd5, 1, 1, 0, 1, 1);
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 0, 0, 8'd0, 0, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 8'd0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0, 1);
        n = 0;
        while (sched.size() != 0) begin
            e = sched.pop_front();
            drive(e);
            n++;
            checks++;
            if ({C, P0, DONE, BUSY, SR} !== {exp_c, e.p0, e.done, e.busy, e.sr}) begin
                errors++;
                $display("FAIL basic_run cyc %0d: {C,P0,DONE,BUSY,SR} got %h want %h",
                         n, {C, P0, DONE, BUSY, SR}, {exp_c, e.p0, e.done, e.busy, e.sr});
            end
        end
    endtask

    task automatic test_halt;
        cyc_t e;
        int   n;
        bit   h[8]  = '{0, 1, 1, 1, 0, 0, 0, 0};
        bit   p[8]  = '{1, 0, 0, 0, 1, 1, 0, 0};
        bit   d[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
        bit   b[8]  = '{1, 1, 1, 1, 1, 1, 0, 0};
        add_shift(17'h0F0F0, 0, 0);
        add(1, 0, 0, 0, 0, 8'd4, 1, 1, 0, 1, 1);
        for (int i = 0; i < 8; i++)
            add(0, h[i], 0, 0, 0, 8'd0, 0, p[i], d[i], b[i], 1);
        n = 0;
        while (sched.size() != 0) begin
            e = sched.pop_front();
            drive(e);
            n++;
            checks++;
            if ({C, P0, DONE, BUSY, SR} !== {exp_c, e.p0, e.done, e.busy, e.sr}) begin
                errors++;
                $display("FAIL halt cyc %0d: {C,P0,DONE,BUSY,SR} got %h want %h",
                         n, {C, P0, DONE, BUSY, SR}, {exp_c, e.p0, e.done, e.busy, e.sr});
            end
        end
    endtask

    task automatic test_double_buffer;
        cyc_t        e;
        int          n;
        logic [16:0] w2 = 17'h00001;
        add_shift(17'h12345, 0, 0);
        add(1, 0, 0, 0, 0, 8'd10, 1, 1, 0, 1, 1);
        // Five enabled cycles, then HALT stretches the run while the next word finishes.
        for (int i = 0; i < 17; i++)
            add(0, i >= 4, 0, 1, w2[i], 8'd0, 0, i < 4, 0, 1, i != 16);
        wq.push_back(w2);
        add(0, 0, 0, 0, 0, 8'd0, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 8'd3, 1, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 8'd0, 0, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 8'd0, 0, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 8'd0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0, 1);
        n = 0;
        while (sched.size() != 0) begin
            e = sched.pop_front();
            drive(e);
            n++;
            checks++;
            if ({C, P0, DONE, BUSY, SR} !== {exp_c, e.p0, e.done, e.busy, e.sr}) begin
                errors++;
                $display("FAIL double_buffer cyc %0d: {C,P0,DONE,BUSY,SR} got %h want %h",
                         n, {C, P0, DONE, BUSY, SR}, {exp_c, e.p0, e.done, e.busy, e.sr});
            end
        end
    endtask

    task automatic test_priority;
        cyc_t e;
        int   n;
        add(1, 0, 0, 0, 0, 8'd7, 0, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 8'd0, 0, 0, 0, 0, 1);
        add_shift(17'h1F00F, 0, 0);
        add(1, 0, 0, 0, 0, 8'd20, 1, 1, 0, 1, 1);
        add_shift(17'h00FF1, 1, 1);
        add(1, 0, 1, 0, 0, 8'd5, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 8'd1, 1, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 8'd0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0, 1);
        n = 0;
        while (sched.size() != 0) begin
            e = sched.pop_front();
            drive(e);
            n++;
            checks++;
            if ({C, P0, DONE, BUSY, SR} !== {exp_c, e.p0, e.done, e.busy, e.sr}) begin
                errors++;
                $display("FAIL priority cyc %0d: {C,P0,DONE,BUSY,SR} got %h want %h",
                         n, {C, P0, DONE, BUSY, SR}, {exp_c, e.p0, e.done, e.busy, e.sr});
            end
        end
    endtask

    task automatic test_free_run;
        cyc_t e;
        int   n;
        add_shift(17'h1FFFF, 0, 0);
        add(1, 0, 0, 0, 0, 8'd0, 1, 1, 0, 1, 1);
        for (int i = 0; i < 300; i++)
            add(0, 0, 0, 0, 0, 8'd0, 0, 1, 0, 1, 1);
        add(0, 0, 1, 0, 0, 8'd0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0, 1);
        n = 0;
        while (sched.size() != 0) begin
            e = sched.pop_front();
            drive(e);
            n++;
            checks++;
            if ({C, P0, DONE, BUSY, SR} !== {exp_c, e.p0, e.done, e.busy, e.sr}) begin
                errors++;
                $display("FAIL free_run cyc %0d: {C,P0,DONE,BUSY,SR} got %h want %h",
                         n, {C, P0, DONE, BUSY, SR}, {exp_c, e.p0, e.done, e.busy, e.sr});
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic_run;
        test_halt;
        test_double_buffer;
        test_priority;
        test_free_run;
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d words left, want 0", wq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, want completion");
        $fatal(1, "time limit");
    end

endmodule
